// File: rtl/ram_req_adapter.sv
// ram_req_adapter
// Front end for a single-port synchronous RAM wrapper. After reset (or on
// request) it zero-fills the whole RAM, then forwards read/write requests
// from a valid/ready port and returns read data through a 3-entry response
// FIFO. Read data from the RAM arrives one cycle after the address, so a
// read accepted in cycle N is visible on the response port in cycle N+2.

module ram_req_adapter #(
    parameter  int WIDTH     = 8,
    parameter  int WORDS     = 2048,
    localparam int ADDR_BITS = $clog2(WORDS)
) (
    input  logic                 clock,
    input  logic                 reset_n,

    // Request port
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,

    // Response port (read data only, oldest first)
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,

    // Zero-fill control
    input  logic                 clear_start,
    output logic                 init_busy,

    // RAM wrapper side
    output logic [ADDR_BITS-1:0] ram_address,
    output logic                 ram_wren,
    output logic [WIDTH-1:0]     ram_write_data,
    input  logic [WIDTH-1:0]     ram_read_data
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int                 FIFO_DEPTH = 3;
    localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(WORDS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,      state_d;
    logic [ADDR_BITS-1:0] cnt_q,        cnt_d;
    logic                 clear_pend_q, clear_pend_d;
    logic                 inflight_q,   inflight_d;

    logic [WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [1:0]           wr_ptr_q,     wr_ptr_d;
    logic [1:0]           rd_ptr_q,     rd_ptr_d;
    logic [1:0]           fifo_count_q, fifo_count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic       in_run;
    logic [2:0] occupancy;
    logic       read_accept;
    logic       fifo_push;
    logic       fifo_pop;

    assign in_run    = (state_q == ST_RUN);

    // Slots already committed: entries stored plus a read whose data is
    // arriving from the RAM this cycle. Independent of rsp_ready so that
    // req_ready has no combinational path from the consumer.
    assign occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q};

    assign req_ready   = in_run && !clear_pend_q && (occupancy < 3'(FIFO_DEPTH));
    assign read_accept = req_valid && req_ready && !req_write;

    // The RAM returns data for last cycle's read address right now.
    assign fifo_push = inflight_q;
    assign rsp_valid = (fifo_count_q != 2'd0);
    assign fifo_pop  = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem_q[rd_ptr_q];

    assign init_busy = !in_run;

    // Circular pointer step over the three FIFO slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic for the START / CLEAR / RUN sequencer
    // ------------------------------------------------------------------
    // Sequencer: one idle START cycle, WORDS zero writes, then RUN; a
    // requested clear waits in RUN until no read data is still in flight.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q;

        case (state_q)
            ST_START: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end

            ST_CLEAR: begin
                // Counter wraps to 0 naturally after the last address.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (clear_pend_q && !inflight_q) begin
                    state_d      = ST_CLEAR;
                    cnt_d        = '0;
                    clear_pend_d = 1'b0;
                end else if (clear_start) begin
                    clear_pend_d = 1'b1;
                end
            end

            default: begin
                state_d      = ST_START;
                cnt_d        = '0;
                clear_pend_d = 1'b0;
            end
        endcase
    end

    // A read accepted this cycle has its data on ram_read_data next cycle.
    assign inflight_d = read_accept;

    // ------------------------------------------------------------------
    // RAM port multiplexing
    // ------------------------------------------------------------------
    // Drive the RAM from the fill counter while clearing, else from requests.
    always_comb begin
        ram_address    = cnt_q;
        ram_write_data = '0;
        ram_wren       = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                ram_address    = cnt_q;
                ram_write_data = '0;
                ram_wren       = 1'b1;
            end

            ST_RUN: begin
                ram_address    = req_addr;
                ram_write_data = req_wdata;
                ram_wren       = req_valid && req_ready && req_write;
            end

            default: begin
                ram_address    = cnt_q;
                ram_write_data = '0;
                ram_wren       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response FIFO bookkeeping
    // ------------------------------------------------------------------
    // Pointer and occupancy update; a simultaneous push and pop keeps the count.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (fifo_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control state: reset returns to START and drops any pending responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_START;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage: capture RAM read data into the write slot.
    // NOTE: the data array has no reset; an entry is only ever read after it
    // has been written, and fifo_count_q gates rsp_valid.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= ram_read_data;
        end
    end

endmodule
